// File: rtl/uart_rx_fifo_if.sv
// Byte-stream handshake between the UART receive FIFO and its producer/consumer.
// The master side drives the write, read and clear strobes; the slave side is the FIFO.
interface uart_rx_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  wr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  rd;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  empty;
    logic                  full;
    logic [ADDR_WIDTH:0]   level;
    logic                  overflow;
    logic                  ovf_clr;

    modport master (
        output wr, w_data, rd, ovf_clr,
        input  r_data, empty, full, level, overflow
    );

    modport slave (
        input  wr, w_data, rd, ovf_clr,
        output r_data, empty, full, level, overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind the UART receiver, with occupancy and sticky overflow.
// Define UART_RX_FIFO_OVERWRITE_EN to keep the newest bytes on overflow instead of the oldest.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_rx_fifo_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LEVEL_FULL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LEVEL_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   level;
    logic                  overflow;
    logic                  is_empty;
    logic                  is_full;
    logic                  ovf_set;
    logic                  push;
    logic                  pop;

    assign is_empty = (level == '0);
    assign is_full  = (level == LEVEL_FULL);
    assign ovf_set  = bus.wr && is_full && !bus.rd;

`ifdef UART_RX_FIFO_OVERWRITE_EN
    // Overflowing write replaces the oldest entry: an implicit pop alongside the push.
    assign push = bus.wr;
    assign pop  = (bus.rd && !is_empty) || ovf_set;
`else
    assign push = bus.wr && !ovf_set;
    assign pop  = bus.rd && !is_empty;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.w_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LEVEL_ONE;
                2'b01:   level <= level - LEVEL_ONE;
                default: level <= level;
            endcase
            // Set has priority so a coincident clear cannot hide a fresh overflow.
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (bus.ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign bus.r_data   = is_empty ? '0 : mem[rd_ptr];
    assign bus.empty    = is_empty;
    assign bus.full     = is_full;
    assign bus.level    = level;
    assign bus.overflow = overflow;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus randomized bench for uart_rx_fifo against a queue-based reference model.
// Build with +define+UART_RX_FIFO_OVERWRITE_EN to check the overwrite variant.
module tb_uart_rx_fifo;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    logic [DW-1:0] q[$];
    bit            m_ovf;

    uart_rx_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    uart_rx_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [DW-1:0] head;
        head = (q.size() == 0) ? '0 : q[0];
        chk({tag, ".level"},    32'(bus.level),    32'(q.size()));
        chk({tag, ".r_data"},   32'(bus.r_data),   32'(head));
        chk({tag, ".empty"},    32'(bus.empty),    32'(q.size() == 0));
        chk({tag, ".full"},     32'(bus.full),     32'(q.size() == DEPTH));
        chk({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
    endtask

    task automatic model_step(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
        logic [DW-1:0] tmp;
        bit was_full;
        was_full = (q.size() == DEPTH);
        if (c) m_ovf = 1'b0;
        if (w && was_full && !r) begin
            m_ovf = 1'b1;
`ifdef UART_RX_FIFO_OVERWRITE_EN
            tmp = q.pop_front();
            q.push_back(d);
`endif
        end else begin
            if (r && q.size() != 0) tmp = q.pop_front();
            if (w) q.push_back(d);
        end
    endtask

    // Called at a negedge; applies one clock of stimulus and checks at the next negedge.
    task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r, input bit c, input string tag);
        bus.wr      = w;
        bus.w_data  = d;
        bus.rd      = r;
        bus.ovf_clr = c;
        @(posedge clk);
        model_step(w, d, r, c);
        @(negedge clk);
        bus.wr      = 1'b0;
        bus.rd      = 1'b0;
        bus.ovf_clr = 1'b0;
        check_model(tag);
    endtask

    task automatic fill(input int n, input logic [DW-1:0] base, input string tag);
        for (int i = 0; i < n; i++) cyc(1'b1, base + DW'(i), 1'b0, 1'b0, tag);
    endtask

    task automatic drain(input string tag);
        while (q.size() != 0) cyc(1'b0, '0, 1'b1, 1'b0, tag);
    endtask

    initial begin
        logic [DW-1:0] exp_drain [DEPTH];
        logic [DW-1:0] d;
        bus.wr = 1'b0; bus.w_data = '0; bus.rd = 1'b0; bus.ovf_clr = 1'b0;
        rst_n = 1'b0;
        m_ovf = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.level", 32'(bus.level), 0);
        chk("reset.empty", 32'(bus.empty), 1);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: async reset mid-burst with overflow set
        fill(17, 8'h40, "t1.fill");
        bus.wr = 1'b1; bus.w_data = 8'h99;
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        m_ovf = 1'b0;
        chk("t1.level",    32'(bus.level),    0);
        chk("t1.empty",    32'(bus.empty),    1);
        chk("t1.full",     32'(bus.full),     0);
        chk("t1.overflow", 32'(bus.overflow), 0);
        chk("t1.r_data",   32'(bus.r_data),   0);
        bus.wr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 2: basic FWFT order
        cyc(1'b1, 8'hA5, 1'b0, 1'b0, "t2.w0");
        chk("t2.head", 32'(bus.r_data), 32'h A5);
        cyc(1'b1, 8'h3C, 1'b0, 1'b0, "t2.w1");
        chk("t2.lvl2", 32'(bus.level), 2);
        chk("t2.head2", 32'(bus.r_data), 32'hA5);
        cyc(1'b0, '0, 1'b1, 1'b0, "t2.r0");
        chk("t2.next", 32'(bus.r_data), 32'h3C);
        chk("t2.lvl1", 32'(bus.level), 1);
        cyc(1'b0, '0, 1'b1, 1'b0, "t2.r1");
        chk("t2.empty", 32'(bus.empty), 1);
        chk("t2.zero", 32'(bus.r_data), 0);

        // 3: fill to full, drain in order, then pointer wrap under streaming
        fill(DEPTH, 8'h00, "t3.fill");
        chk("t3.full", 32'(bus.full), 1);
        chk("t3.lvl16", 32'(bus.level), 16);
        for (int i = 0; i < DEPTH; i++) begin
            chk("t3.order", 32'(bus.r_data), 32'(i));
            cyc(1'b0, '0, 1'b1, 1'b0, "t3.drain");
        end
        chk("t3.empty", 32'(bus.empty), 1);
        fill(3, 8'hC0, "t3.pre");
        for (int i = 0; i < 20; i++) cyc(1'b1, DW'($urandom), 1'b1, 1'b0, "t3.wrap");
        drain("t3.post");

        // 4: overflow while full
        fill(DEPTH, 8'h00, "t4.fill");
        cyc(1'b1, 8'h55, 1'b0, 1'b0, "t4.ovf");
        chk("t4.ovf_set", 32'(bus.overflow), 1);
        for (int i = 0; i < DEPTH; i++) begin
`ifdef UART_RX_FIFO_OVERWRITE_EN
            exp_drain[i] = (i < DEPTH - 1) ? DW'(i + 1) : 8'h55;
`else
            exp_drain[i] = DW'(i);
`endif
        end
        for (int i = 0; i < DEPTH; i++) begin
            chk("t4.drain", 32'(bus.r_data), 32'(exp_drain[i]));
            cyc(1'b0, '0, 1'b1, 1'b0, "t4.pop");
        end
        cyc(1'b0, '0, 1'b0, 1'b1, "t4.clr");
        chk("t4.ovf_clr", 32'(bus.overflow), 0);

        // 5: simultaneous write and read at empty, mid, full
        cyc(1'b1, 8'h7E, 1'b1, 1'b0, "t5.empty");
        chk("t5.lvl1", 32'(bus.level), 1);
        chk("t5.data", 32'(bus.r_data), 32'h7E);
        fill(4, 8'h10, "t5.fill5");
        cyc(1'b1, 8'h20, 1'b1, 1'b0, "t5.mid");
        chk("t5.lvl5", 32'(bus.level), 5);
        fill(11, 8'h30, "t5.fill16");
        cyc(1'b1, 8'h21, 1'b1, 1'b0, "t5.full");
        chk("t5.lvl16", 32'(bus.level), 16);
        chk("t5.noovf", 32'(bus.overflow), 0);
        drain("t5.drain");

        // 6: read while empty, then clear coincident with overflowing write
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0, "t6.rd_empty");
        chk("t6.lvl0", 32'(bus.level), 0);
        fill(DEPTH, 8'h80, "t6.fill");
        cyc(1'b1, 8'hEE, 1'b0, 1'b1, "t6.setwins");
        chk("t6.ovf", 32'(bus.overflow), 1);
        cyc(1'b0, '0, 1'b0, 1'b1, "t6.clr");
        drain("t6.drain");

        // Randomized traffic: write-heavy phase then read-heavy phase
        for (int i = 0; i < 400; i++) begin
            bit w, r, c;
            d = DW'($urandom);
            if (i < 200) begin
                w = ($urandom_range(0, 9) < 7);
                r = ($urandom_range(0, 9) < 3);
            end else begin
                w = ($urandom_range(0, 9) < 3);
                r = ($urandom_range(0, 9) < 7);
            end
            c = ($urandom_range(0, 19) == 0);
            cyc(w, d, r, c, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
